// File: rtl/wb_regfile_stage_if.sv
// MEM/WB-to-writeback bundle: buffered instruction fields in, decode read ports,
// stall and write-forwarding information back out.
interface wb_regfile_stage_if #(
    parameter int DATA_W = 16
);
    logic              valid_in;
    logic              MemToReg_in;
    logic              RegWrite_in;
    logic [3:0]        WriteReg_in;
    logic [DATA_W-1:0] ALU_Result;
    logic [DATA_W-1:0] ReadData;
    logic [3:0]        movOP_in;
    logic              RemWrite_in;
    logic [DATA_W-1:0] Remainder_in;
    logic              stall_out;
    logic [3:0]        ReadReg1;
    logic [3:0]        ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              fwd_valid;
    logic [3:0]        fwd_reg;
    logic [DATA_W-1:0] fwd_data;

    modport master (
        output valid_in, MemToReg_in, RegWrite_in, WriteReg_in, ALU_Result, ReadData,
               movOP_in, RemWrite_in, Remainder_in, ReadReg1, ReadReg2,
        input  stall_out, ReadData1, ReadData2, fwd_valid, fwd_reg, fwd_data
    );

    modport slave (
        input  valid_in, MemToReg_in, RegWrite_in, WriteReg_in, ALU_Result, ReadData,
               movOP_in, RemWrite_in, Remainder_in, ReadReg1, ReadReg2,
        output stall_out, ReadData1, ReadData2, fwd_valid, fwd_reg, fwd_data
    );
endinterface

// File: rtl/wb_regfile_stage.sv
// Writeback stage + 16x16 register file with write bypass; divide remainders
// are committed to REM_REG in an extra stalled cycle.
module wb_regfile_stage #(
    parameter int         DATA_W  = 16,
    parameter logic [3:0] REM_REG = 4'd15
) (
    input  logic               clk,
    input  logic               rst_n,
    wb_regfile_stage_if.slave  bus
);
    typedef enum logic {IDLE, REM} state_t;

    state_t            state_reg;
    logic [DATA_W-1:0] rem_data_reg;
    logic [DATA_W-1:0] regs [16];

    logic [DATA_W-1:0] src;
    logic [DATA_W-1:0] old;
    logic [DATA_W-1:0] wdata;
    logic              commit_valid;
    logic [3:0]        commit_reg;
    logic [DATA_W-1:0] commit_data;

    assign src = bus.MemToReg_in ? bus.ReadData : bus.ALU_Result;
    assign old = regs[bus.WriteReg_in];

    always_comb begin
        wdata = src;
        case (bus.movOP_in)
            4'd1:    wdata = {old[15:8], src[7:0]};
            4'd2:    wdata = {src[7:0], old[7:0]};
            4'd3:    wdata = {src[7:0], src[15:8]};
            4'd4:    wdata = {{8{src[7]}}, src[7:0]};
            4'd5:    wdata = {8'h00, src[7:0]};
            4'd6:    wdata = '0;
            default: wdata = src;
        endcase
    end

    // The single commit port is shared: main write in IDLE, remainder in REM.
    always_comb begin
        commit_valid = 1'b0;
        commit_reg   = bus.WriteReg_in;
        commit_data  = wdata;
        if (state_reg == REM) begin
            commit_valid = (REM_REG != 4'd0);
            commit_reg   = REM_REG;
            commit_data  = rem_data_reg;
        end else begin
            commit_valid = bus.valid_in && bus.RegWrite_in && (bus.WriteReg_in != 4'd0);
        end
    end

    assign bus.fwd_valid = commit_valid;
    assign bus.fwd_reg   = commit_reg;
    assign bus.fwd_data  = commit_data;
    assign bus.stall_out = (state_reg == REM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            rem_data_reg <= '0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (commit_valid) begin
                regs[commit_reg] <= commit_data;
            end
            case (state_reg)
                IDLE: begin
                    if (bus.valid_in && bus.RemWrite_in) begin
                        rem_data_reg <= bus.Remainder_in;
                        state_reg    <= REM;
                    end
                end
                REM:     state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    logic [3:0]        raddr [2];
    logic [DATA_W-1:0] rdata [2];

    assign raddr[0]      = bus.ReadReg1;
    assign raddr[1]      = bus.ReadReg2;
    assign bus.ReadData1 = rdata[0];
    assign bus.ReadData2 = rdata[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            always_comb begin
                rdata[gi] = regs[raddr[gi]];
                if (raddr[gi] == 4'd0) begin
                    rdata[gi] = '0;
                end else if (commit_valid && (commit_reg == raddr[gi])) begin
                    rdata[gi] = commit_data;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed and randomized checks of the writeback stage against a simple
// register-array model with a pending-remainder flag.
module tb_wb_regfile_stage;
    logic clk;
    logic rst_n;

    wb_regfile_stage_if #(.DATA_W(16)) bus ();

    wb_regfile_stage #(.DATA_W(16), .REM_REG(4'd15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] mregs [16];
    logic        m_pend;
    logic [15:0] m_rem;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic m2r, input logic rw, input logic [3:0] wr,
                         input logic [15:0] alu, input logic [15:0] rd, input logic [3:0] mov,
                         input logic remw, input logic [15:0] rem);
        bus.valid_in     = v;
        bus.MemToReg_in  = m2r;
        bus.RegWrite_in  = rw;
        bus.WriteReg_in  = wr;
        bus.ALU_Result   = alu;
        bus.ReadData     = rd;
        bus.movOP_in     = mov;
        bus.RemWrite_in  = remw;
        bus.Remainder_in = rem;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 16'h0, 4'd0, 1'b0, 16'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_reg(input logic [3:0] r, output logic [15:0] d);
        bus.ReadReg1 = r;
        #1;
        d = bus.ReadData1;
    endtask

    // Write value from the move-operation table.
    function automatic logic [15:0] mov_value(input logic [3:0] mov, input logic [15:0] s,
                                              input logic [15:0] o);
        logic [7:0] sl, sh, ol, oh;
        sl = s[7:0]; sh = s[15:8]; ol = o[7:0]; oh = o[15:8];
        case (mov)
            4'd1: return {oh, sl};
            4'd2: return {sl, ol};
            4'd3: return {sl, sh};
            4'd4: return sl[7] ? {8'hFF, sl} : {8'h00, sl};
            4'd5: return {8'h00, sl};
            4'd6: return 16'h0000;
            default: return s;
        endcase
    endfunction

    logic [15:0] d;
    logic [3:0]  mov_codes [7];
    logic [15:0] mov_exp   [7];

    initial begin
        mov_codes = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd9};
        mov_exp   = '{16'hAAF4, 16'hF455, 16'hF412, 16'hFFF4, 16'h00F4, 16'h0000, 16'h12F4};
        idle_in();
        bus.ReadReg1 = 4'd0;
        bus.ReadReg2 = 4'd0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        chk("rst_stall", 16'(bus.stall_out), 16'h0);
        chk("rst_fwd_valid", 16'(bus.fwd_valid), 16'h0);
        for (int r = 0; r < 16; r++) begin
            read_reg(4'(r), d);
            chk($sformatf("rst_reg%0d", r), d, 16'h0);
        end
        rst_n = 1'b1;
        tick();

        // reset clears a written register
        drive(1'b1, 1'b0, 1'b1, 4'd3, 16'h1234, 16'h0, 4'd0, 1'b0, 16'h0);
        tick();
        idle_in();
        read_reg(4'd3, d);
        chk("r3_written", d, 16'h1234);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        read_reg(4'd3, d);
        chk("r3_after_rst", d, 16'h0);
        chk("rst2_stall", 16'(bus.stall_out), 16'h0);
        chk("rst2_fwd_valid", 16'(bus.fwd_valid), 16'h0);
        $display("txn reset: R3 cleared");

        // memory/ALU mux and same-cycle bypass
        drive(1'b1, 1'b1, 1'b1, 4'd5, 16'h0001, 16'hBEEF, 4'd0, 1'b0, 16'h0);
        bus.ReadReg1 = 4'd5;
        #1;
        chk("bypass_rd1", bus.ReadData1, 16'hBEEF);
        chk("bypass_fwd_valid", 16'(bus.fwd_valid), 16'h1);
        chk("bypass_fwd_reg", 16'(bus.fwd_reg), 16'h5);
        tick();
        idle_in();
        read_reg(4'd5, d);
        chk("r5_committed", d, 16'hBEEF);
        $display("txn mux/bypass: R5=%h", d);

        // movOP sweep on R2
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, 1'b1, 4'd2, 16'hAA55, 16'h0, 4'd0, 1'b0, 16'h0);
            tick();
            drive(1'b1, 1'b0, 1'b1, 4'd2, 16'h12F4, 16'h0, mov_codes[i], 1'b0, 16'h0);
            #1;
            chk($sformatf("mov%0d_fwd", mov_codes[i]), bus.fwd_data, mov_exp[i]);
            tick();
            idle_in();
            read_reg(4'd2, d);
            chk($sformatf("mov%0d_r2", mov_codes[i]), d, mov_exp[i]);
            $display("txn movOP=%0d: R2=%h", mov_codes[i], d);
        end

        // remainder write with stall
        drive(1'b1, 1'b0, 1'b1, 4'd4, 16'h0007, 16'h0, 4'd0, 1'b1, 16'h0003);
        #1;
        chk("rem_stall_pre", 16'(bus.stall_out), 16'h0);
        tick();
        idle_in();
        bus.ReadReg1 = 4'd4;
        bus.ReadReg2 = 4'd15;
        #1;
        chk("rem_stall_hi", 16'(bus.stall_out), 16'h1);
        chk("rem_r4", bus.ReadData1, 16'h0007);
        chk("rem_r15_bypass", bus.ReadData2, 16'h0003);
        chk("rem_fwd_reg", 16'(bus.fwd_reg), 16'hF);
        tick();
        chk("rem_stall_lo", 16'(bus.stall_out), 16'h0);
        read_reg(4'd15, d);
        chk("rem_r15", d, 16'h0003);
        $display("txn remainder: R15=%h", d);

        // R15 collision: remainder overwrites main write
        drive(1'b1, 1'b0, 1'b1, 4'd15, 16'h00FF, 16'h0, 4'd0, 1'b1, 16'h0002);
        tick();
        idle_in();
        #1;
        chk("coll_r15_edge1", dut.regs[15], 16'h00FF);
        chk("coll_stall", 16'(bus.stall_out), 16'h1);
        tick();
        read_reg(4'd15, d);
        chk("coll_r15_edge2", d, 16'h0002);
        $display("txn collision: R15=%h", d);

        // back-to-back remainder instructions
        drive(1'b1, 1'b0, 1'b1, 4'd6, 16'h000A, 16'h0, 4'd0, 1'b1, 16'h0011);
        tick();
        drive(1'b1, 1'b0, 1'b1, 4'd7, 16'h000B, 16'h0, 4'd0, 1'b1, 16'h0022);
        #1;
        chk("b2b_stall1", 16'(bus.stall_out), 16'h1);
        chk("b2b_fwd1", bus.fwd_data, 16'h0011);
        tick();
        #1;
        chk("b2b_idle_stall", 16'(bus.stall_out), 16'h0);
        chk("b2b_fwd_reg2", 16'(bus.fwd_reg), 16'h7);
        chk("b2b_fwd2", bus.fwd_data, 16'h000B);
        tick();
        idle_in();
        #1;
        chk("b2b_stall2", 16'(bus.stall_out), 16'h1);
        chk("b2b_fwd3", bus.fwd_data, 16'h0022);
        tick();
        chk("b2b_stall_end", 16'(bus.stall_out), 16'h0);
        read_reg(4'd6, d);
        chk("b2b_r6", d, 16'h000A);
        read_reg(4'd7, d);
        chk("b2b_r7", d, 16'h000B);
        read_reg(4'd15, d);
        chk("b2b_r15", d, 16'h0022);
        $display("txn back-to-back remainders: R15=%h", d);

        // R0 is hard-wired
        drive(1'b1, 1'b0, 1'b1, 4'd0, 16'hFFFF, 16'h0, 4'd0, 1'b0, 16'h0);
        bus.ReadReg1 = 4'd0;
        #1;
        chk("r0_fwd_valid", 16'(bus.fwd_valid), 16'h0);
        chk("r0_rd_same", bus.ReadData1, 16'h0);
        tick();
        idle_in();
        read_reg(4'd0, d);
        chk("r0_after", d, 16'h0);
        $display("txn R0 write: R0=%h", d);

        // reset during REM loses the pending remainder
        drive(1'b1, 1'b0, 1'b1, 4'd8, 16'h0055, 16'h0, 4'd0, 1'b1, 16'h0099);
        tick();
        idle_in();
        rst_n = 1'b0;
        #1;
        chk("rstrem_stall_pre", 16'(bus.stall_out), 16'h1);
        tick();
        rst_n = 1'b1;
        chk("rstrem_stall", 16'(bus.stall_out), 16'h0);
        chk("rstrem_fwd_valid", 16'(bus.fwd_valid), 16'h0);
        tick();
        chk("rstrem_stall2", 16'(bus.stall_out), 16'h0);
        read_reg(4'd15, d);
        chk("rstrem_r15", d, 16'h0);
        read_reg(4'd8, d);
        chk("rstrem_r8", d, 16'h0);
        $display("txn reset in REM: R15=%h", d);

        // randomized run against the model
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int r = 0; r < 16; r++) mregs[r] = 16'h0;
        m_pend = 1'b0;
        m_rem  = 16'h0;
        for (int n = 0; n < 300; n++) begin
            logic        e_valid;
            logic [3:0]  e_reg;
            logic [15:0] e_data;
            logic [15:0] srcv;
            logic [3:0]  rr1, rr2;
            drive(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 4'($urandom),
                  16'($urandom), 16'($urandom), 4'($urandom_range(0, 10)),
                  ($urandom_range(0, 3) == 0), 16'($urandom));
            rr1 = 4'($urandom);
            rr2 = 4'($urandom);
            bus.ReadReg1 = rr1;
            bus.ReadReg2 = rr2;
            #1;
            if (m_pend) begin
                e_valid = 1'b1;
                e_reg   = 4'd15;
                e_data  = m_rem;
            end else begin
                srcv    = bus.MemToReg_in ? bus.ReadData : bus.ALU_Result;
                e_valid = bus.valid_in && bus.RegWrite_in && (bus.WriteReg_in != 4'd0);
                e_reg   = bus.WriteReg_in;
                e_data  = mov_value(bus.movOP_in, srcv, mregs[bus.WriteReg_in]);
            end
            chk("rnd_stall", 16'(bus.stall_out), 16'(m_pend));
            chk("rnd_fwd_valid", 16'(bus.fwd_valid), 16'(e_valid));
            if (e_valid) begin
                chk("rnd_fwd_reg", 16'(bus.fwd_reg), 16'(e_reg));
                chk("rnd_fwd_data", bus.fwd_data, e_data);
            end
            chk("rnd_rd1", bus.ReadData1,
                (rr1 == 4'd0) ? 16'h0 : ((e_valid && e_reg == rr1) ? e_data : mregs[rr1]));
            chk("rnd_rd2", bus.ReadData2,
                (rr2 == 4'd0) ? 16'h0 : ((e_valid && e_reg == rr2) ? e_data : mregs[rr2]));
            $display("txn rnd %0d: pend=%0d fwd=%0d R%0d<=%h", n, m_pend, e_valid, e_reg, e_data);
            if (e_valid) mregs[e_reg] = e_data;
            if (m_pend) begin
                m_pend = 1'b0;
            end else if (bus.valid_in && bus.RemWrite_in) begin
                m_pend = 1'b1;
                m_rem  = bus.Remainder_in;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_regfile_stage.md
# wb_regfile_stage

Writeback stage and register file for the 16-bit pipeline, sitting directly after the MEM/WB buffer. It consumes the buffered control and data, selects ALU or memory data, and applies the move operation. It commits results to a 16×16 register file and serves the decode-stage read ports with same-cycle write bypass. Divide results carry a remainder, which is committed to R15 in a second cycle, with a stall back to the pipeline.

## Interface
Parameters:
- DATA_W, 16, register and datapath width
- REM_REG, 4'd15, destination register for the divide remainder

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- valid_in  in  1  MEM/WB slot holds a real instruction
- MemToReg_in  in  1  1 = write ReadData, 0 = write ALU_Result
- RegWrite_in  in  1  instruction writes a register
- WriteReg_in  in  4  destination register
- ALU_Result  in  16  ALU result from MEM/WB
- ReadData  in  16  memory read data from MEM/WB
- movOP_in  in  4  move-operation code
- RemWrite_in  in  1  instruction also produces a remainder
- Remainder_in  in  16  remainder value
- stall_out  out  1  upstream must hold MEM/WB contents this cycle
- ReadReg1, ReadReg2  in  4 each  decode read addresses
- ReadData1, ReadData2  out  16 each  decode read data
- fwd_valid  out  1  a register write commits this cycle
- fwd_reg  out  4  register being written
- fwd_data  out  16  value being written

## Operation
- src = MemToReg_in ? ReadData : ALU_Result.
- old = current register-file contents of WriteReg_in.
- movOP_in sets the main write value wdata:
  - 0: src
  - 1 (MOVL): {old[15:8], src[7:0]}
  - 2 (MOVH): {src[7:0], old[7:0]}
  - 3 (SWAP): {src[7:0], src[15:8]}
  - 4 (SEXT): {{8{src[7]}}, src[7:0]}
  - 5 (ZEXT): {8'h00, src[7:0]}
  - 6 (CLR): 16'h0000
  - 7–15: src
- R0 is hard-wired to 0. Writes to R0 are discarded, and fwd_valid stays 0 for them.
- The FSM has two states, IDLE and REM.
- IDLE behaviour:
  - If valid_in & RegWrite_in, write wdata to WriteReg_in.
  - If valid_in & RemWrite_in, latch Remainder_in and go to REM. This happens even when RegWrite_in=0.
  - Otherwise stay in IDLE.
- REM behaviour:
  - Write the latched remainder to REM_REG, drive stall_out=1, and return to IDLE.
  - All MEM/WB inputs are ignored in REM. Upstream holds them, and the held instruction is processed in IDLE on the following cycle.
- If WriteReg_in == REM_REG with RemWrite_in, the main value is written first. The remainder overwrites it one cycle later, so the final R15 value is the remainder.
- Read ports are combinational from the array, with bypass:
  - If ReadRegN equals the register being written this cycle (fwd_valid & fwd_reg == ReadRegN), ReadDataN = fwd_data.
  - ReadRegN == 0 always returns 0.
- The fwd_* outputs are combinational and describe the write committing at the next rising edge:
  - In IDLE they reflect the main write.
  - In REM they reflect the remainder write.

## Timing
- Reset (rst_n=0 at a rising edge):
  - All 16 registers clear to 0.
  - State goes to IDLE and the latched remainder clears to 0.
  - stall_out=0 and fwd_valid=0.
  - Reset overrides any in-progress REM. A remainder pending during reset is lost.
- A main write commits at the rising edge ending the cycle in which it is presented. Latency is 1 cycle to the array and 0 cycles to the read ports via bypass.
- A remainder write commits one cycle after its main write.
- stall_out is asserted for exactly the single cycle spent in REM, and is combinational from state.
- Back-to-back remainder instructions: the second instruction is held by upstream during REM and accepted in the next IDLE cycle. The sequence is 1 stall cycle per remainder instruction, with no gap otherwise.
- valid_in=0 produces no write and no state change.

## Test plan
- Reset:
  - Stimulus: write R3=16'h1234, then assert rst_n=0 for one edge.
  - Required: ReadData1 for R3 reads 0, stall_out=0, fwd_valid=0.
- Mux and bypass:
  - Stimulus: MemToReg=1, ReadData=16'hBEEF, ALU_Result=16'h0001, WriteReg=5, ReadReg1=5 in the same cycle.
  - Required: ReadData1=16'hBEEF that cycle, and R5=16'hBEEF after the edge.
- movOP sweep, with R2 preloaded to 16'hAA55 and src=16'h12F4, WriteReg=2:
  - MOVL → 16'hAAF4
  - MOVH → 16'hF455
  - SWAP → 16'hF412
  - SEXT → 16'hFFF4
  - ZEXT → 16'h00F4
  - CLR → 16'h0000
  - code 9 → 16'h12F4
- Remainder:
  - Stimulus: RegWrite=1, WriteReg=4, ALU=16'h0007, RemWrite=1, Remainder=16'h0003.
  - Required at edge 1: R4=7 and stall_out goes high.
  - Required at edge 2: R15=3 and stall_out goes low.
- R15 collision:
  - Stimulus: WriteReg=15, ALU=16'h00FF, RemWrite=1, Remainder=16'h0002.
  - Required: R15=16'h00FF after 1 edge and 16'h0002 after 2 edges.
- R0 and reset during REM:
  - Stimulus: write 16'hFFFF to R0.
  - Required: R0 still reads 0 and fwd_valid=0.
  - Stimulus: a remainder instruction, with rst_n=0 applied during the REM cycle.
  - Required: R15=0, state IDLE, stall_out=0.
